// File: rtl/swc_pkg.sv
// Shared constants and helpers for the switch core read-side scheduler
// and the arbiters that reuse its picker.
package swc_pkg;

  localparam int NPORT = 4;
  localparam int WW    = 4;

  typedef logic [WW-1:0] credit_t;

  localparam logic [1:0] SCH_IDLE = 2'd0;
  localparam logic [1:0] SCH_ARB  = 2'd1;
  localparam logic [1:0] SCH_BUSY = 2'd2;

  function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_out_sched_if.sv
// Queue-controller and read-sequencer handshake bundle of the output scheduler.
// The scheduler side uses modport master, its environment uses modport slave.
interface switch_out_sched_if;
  import swc_pkg::*;

  logic [NPORT-1:0] ptr_rdy;
  logic [NPORT-1:0] o_cell_bp;
  logic [NPORT-1:0] head_last;
  logic [NPORT-1:0] ptr_ack;
  logic [NPORT-1:0] sel;
  logic [1:0]       sel_idx;
  logic             rd_start;
  logic             rd_done;
  logic             busy;

  modport master (
    input  ptr_rdy, o_cell_bp, head_last, rd_done,
    output ptr_ack, sel, sel_idx, rd_start, busy
  );

  modport slave (
    output ptr_rdy, o_cell_bp, head_last, rd_done,
    input  ptr_ack, sel, sel_idx, rd_start, busy
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating-priority picker: first set bit of elig
// starting at rr_ptr and wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] elig,
  input  logic [1:0] rr_ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] pos;

  // Scan from the farthest offset back to rr_ptr so the nearest hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = 3; k >= 0; k--) begin
      pos = rr_ptr + 2'(k);
      if (elig[pos]) begin
        gnt     = 4'b0001 << pos;
        gnt_idx = pos;
      end
    end
  end

endmodule

// File: rtl/switch_out_sched.sv
// Weighted round-robin output scheduler: grants one queue head per cell read
// and holds the selection until the read sequencer reports completion.
module switch_out_sched
  import swc_pkg::*;
#(
  parameter int CHARGE_PER_FRAME = 0
) (
  input  logic                clk,
  input  logic                rstn,
  switch_out_sched_if.master  bus,
  input  logic [NPORT*WW-1:0] cfg_weight,
  input  logic                cfg_load
);

  logic [1:0]       state_q, state_d;
  logic [NPORT-1:0] req_q, req_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  credit_t          weight_q [NPORT];
  credit_t          weight_d [NPORT];
  credit_t          credit_q [NPORT];
  credit_t          credit_d [NPORT];
  credit_t          reload_w [NPORT];
  logic [NPORT-1:0] ptr_ack_q, ptr_ack_d;
  logic [NPORT-1:0] sel_q, sel_d;
  logic [1:0]       sel_idx_q, sel_idx_d;
  logic             rd_start_q, rd_start_d;
  logic             busy_q, busy_d;

  logic [NPORT-1:0] req, has_credit, elig, gnt;
  logic [1:0]       gnt_idx;
  logic             reload, charge;

  assign req = bus.ptr_rdy & ~bus.o_cell_bp;

  // A reload coinciding with cfg_load must see the freshly written weights.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      weight_d[i]   = cfg_load ? cfg_weight[i*WW +: WW] : weight_q[i];
      reload_w[i]   = (weight_d[i] == '0) ? credit_t'(1) : weight_d[i];
      has_credit[i] = (credit_q[i] != '0);
    end
  end

  assign reload = ((req_q & has_credit) == '0);
  assign elig   = reload ? req_q : (req_q & has_credit);
  assign charge = (CHARGE_PER_FRAME == 0) || bus.head_last[gnt_idx];

  rr_pick4 u_pick (
    .elig    (elig),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rr_ptr_d   = rr_ptr_q;
    credit_d   = credit_q;
    ptr_ack_d  = '0;
    rd_start_d = 1'b0;
    sel_d      = sel_q;
    sel_idx_d  = sel_idx_q;
    busy_d     = busy_q;
    case (state_q)
      SCH_IDLE: begin
        if (req != '0) begin
          req_d   = req;
          state_d = SCH_ARB;
        end
      end
      SCH_ARB: begin
        if (reload) begin
          for (int i = 0; i < NPORT; i++) credit_d[i] = reload_w[i];
        end
        // Charging saturates at zero; an empty port is still served via reload.
        if (charge && credit_d[gnt_idx] != '0) begin
          credit_d[gnt_idx] = credit_d[gnt_idx] - credit_t'(1);
        end
        ptr_ack_d  = gnt;
        rd_start_d = 1'b1;
        sel_d      = gnt;
        sel_idx_d  = gnt_idx;
        busy_d     = 1'b1;
        rr_ptr_d   = gnt_idx + 2'd1;
        state_d    = SCH_BUSY;
      end
      SCH_BUSY: begin
        if (bus.rd_done) begin
          busy_d    = 1'b0;
          sel_d     = '0;
          sel_idx_d = '0;
          state_d   = SCH_IDLE;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SCH_IDLE;
      req_q      <= '0;
      rr_ptr_q   <= '0;
      ptr_ack_q  <= '0;
      sel_q      <= '0;
      sel_idx_q  <= '0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        weight_q[i] <= credit_t'(1);
        credit_q[i] <= credit_t'(1);
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rr_ptr_q   <= rr_ptr_d;
      ptr_ack_q  <= ptr_ack_d;
      sel_q      <= sel_d;
      sel_idx_q  <= sel_idx_d;
      rd_start_q <= rd_start_d;
      busy_q     <= busy_d;
      weight_q   <= weight_d;
      credit_q   <= credit_d;
    end
  end

  assign bus.ptr_ack  = ptr_ack_q;
  assign bus.sel      = sel_q;
  assign bus.sel_idx  = sel_idx_q;
  assign bus.rd_start = rd_start_q;
  assign bus.busy     = busy_q;

endmodule
